// File: rtl/flipflop_pipe.sv
// Elastic register pipeline with valid/ready handshake, flush and bubble collapse.
// Define FLIPFLOP_PIPE_PARITY_EN to carry an even-parity bit with each word (qout_par).
module flipflop_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           qin,
  input  logic                       qin_valid,
  output logic                       qin_ready,
  output logic [WIDTH-1:0]           qout,
  output logic                       qout_valid,
  input  logic                       qout_ready,
  input  logic                       flush,
`ifdef FLIPFLOP_PIPE_PARITY_EN
  output logic                       qout_par,
`endif
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] vld_q, vld_d, adv;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];
  logic [OW-1:0]    cnt;
  logic             adv_c;

`ifdef FLIPFLOP_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q, par_d;
`endif

  // Stage k may load when it is empty or its successor moves on.
  always_comb begin
    adv_c = qout_ready;
    adv   = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      adv_c  = !vld_q[k] || adv_c;
      adv[k] = adv_c;
    end
  end

  assign qin_ready = !reset && !flush && adv[0];

  always_comb begin
    vld_d = vld_q;
    for (int k = 0; k < DEPTH; k++) dat_d[k] = dat_q[k];
`ifdef FLIPFLOP_PIPE_PARITY_EN
    par_d = par_q;
`endif
    if (adv[0]) begin
      vld_d[0] = qin_valid && qin_ready;
      dat_d[0] = qin;
`ifdef FLIPFLOP_PIPE_PARITY_EN
      par_d[0] = ^qin;
`endif
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (adv[k]) begin
        vld_d[k] = vld_q[k-1];
        dat_d[k] = dat_q[k-1];
`ifdef FLIPFLOP_PIPE_PARITY_EN
        par_d[k] = par_q[k-1];
`endif
      end
    end
    if (flush) vld_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) dat_q[k] <= '0;
`ifdef FLIPFLOP_PIPE_PARITY_EN
      par_q <= '0;
`endif
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < DEPTH; k++) dat_q[k] <= dat_d[k];
`ifdef FLIPFLOP_PIPE_PARITY_EN
      par_q <= par_d;
`endif
    end
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) cnt = cnt + OW'(vld_q[k]);
  end

  assign occupancy  = cnt;
  assign qout       = dat_q[DEPTH-1];
  assign qout_valid = vld_q[DEPTH-1];
`ifdef FLIPFLOP_PIPE_PARITY_EN
  assign qout_par   = par_q[DEPTH-1];
`endif

endmodule
